// File: rtl/mchan_cmd_unpack.sv
// MCHAN command unpacker: splits one queued 1D transfer command into bursts
// bounded by MAX_BURST_BYTES and, with MCHAN_UNPACK_BOUNDARY_EN, the external boundary.
module mchan_cmd_unpack #(
    parameter int MAX_BURST_BYTES = 256,
    parameter int BOUNDARY_LOG2   = 12,
    parameter int MCHAN_LEN_WIDTH = 17,
    parameter int MCHAN_OPC_WIDTH = 1,
    parameter int TRANS_SID_WIDTH = 2,
    parameter int TCDM_ADD_WIDTH  = 32,
    parameter int EXT_ADD_WIDTH   = 32,
    parameter int BURST_LEN_WIDTH = $clog2(MAX_BURST_BYTES)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cmd_req_i,
    output logic                       cmd_gnt_o,
    input  logic [MCHAN_LEN_WIDTH-1:0] cmd_len_i,
    input  logic [MCHAN_OPC_WIDTH-1:0] cmd_opc_i,
    input  logic                       cmd_inc_i,
    input  logic [TRANS_SID_WIDTH-1:0] cmd_sid_i,
    input  logic [TCDM_ADD_WIDTH-1:0]  tcdm_add_i,
    input  logic [EXT_ADD_WIDTH-1:0]   ext_add_i,
    output logic                       tx_req_o,
    input  logic                       tx_gnt_i,
    output logic [BURST_LEN_WIDTH-1:0] tx_len_o,
    output logic [MCHAN_OPC_WIDTH-1:0] tx_opc_o,
    output logic [TRANS_SID_WIDTH-1:0] tx_sid_o,
    output logic [TCDM_ADD_WIDTH-1:0]  tx_tcdm_add_o,
    output logic [EXT_ADD_WIDTH-1:0]   tx_ext_add_o,
    output logic                       tx_last_o,
    output logic                       busy_o
);

    // Byte-count width wide enough for both rem+1 and the boundary distance
    localparam int CW = (MCHAN_LEN_WIDTH > BOUNDARY_LOG2) ? MCHAN_LEN_WIDTH + 1
                                                           : BOUNDARY_LOG2 + 1;

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t                     state;
    logic [MCHAN_LEN_WIDTH-1:0] rem;
    logic [MCHAN_OPC_WIDTH-1:0] opc;
    logic [TRANS_SID_WIDTH-1:0] sid;
    logic                       inc;
    logic [TCDM_ADD_WIDTH-1:0]  tcdm_add;
    logic [EXT_ADD_WIDTH-1:0]   ext_add;

    logic [CW-1:0] avail;
    logic [CW-1:0] burst;
    logic          last_burst;

`ifdef MCHAN_UNPACK_BOUNDARY_EN
    localparam int BW = BOUNDARY_LOG2 + 1;
    logic [BW-1:0] to_bnd;
`endif

    always_comb begin
        avail = CW'(rem) + CW'(1);
        burst = avail;
        if (burst > CW'(MAX_BURST_BYTES))
            burst = CW'(MAX_BURST_BYTES);
`ifdef MCHAN_UNPACK_BOUNDARY_EN
        to_bnd = BW'(1 << BOUNDARY_LOG2) - {1'b0, ext_add[BOUNDARY_LOG2-1:0]};
        if (inc && (CW'(to_bnd) < burst))
            burst = CW'(to_bnd);
`endif
        last_burst = (burst == avail);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            rem      <= '0;
            opc      <= '0;
            sid      <= '0;
            inc      <= 1'b0;
            tcdm_add <= '0;
            ext_add  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_req_i) begin
                        rem      <= cmd_len_i;
                        opc      <= cmd_opc_i;
                        sid      <= cmd_sid_i;
                        inc      <= cmd_inc_i;
                        tcdm_add <= tcdm_add_i;
                        ext_add  <= ext_add_i;
                        state    <= SPLIT;
                    end
                end
                SPLIT: begin
                    if (tx_gnt_i) begin
                        if (last_burst) begin
                            state <= IDLE;
                        end else begin
                            // burst < avail here, so rem cannot underflow
                            rem      <= rem - MCHAN_LEN_WIDTH'(burst);
                            tcdm_add <= tcdm_add + TCDM_ADD_WIDTH'(burst);
                            if (inc)
                                ext_add <= ext_add + EXT_ADD_WIDTH'(burst);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_gnt_o     = (state == IDLE);
    assign tx_req_o      = (state == SPLIT);
    assign busy_o        = (state == SPLIT);
    assign tx_len_o      = BURST_LEN_WIDTH'(burst - CW'(1));
    assign tx_last_o     = (state == SPLIT) && last_burst;
    assign tx_opc_o      = opc;
    assign tx_sid_o      = sid;
    assign tx_tcdm_add_o = tcdm_add;
    assign tx_ext_add_o  = ext_add;

endmodule

// File: tb/tb_mchan_cmd_unpack.sv
// Directed self-checking bench for mchan_cmd_unpack (default parameters).
module tb_mchan_cmd_unpack;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_req_i = 1'b0;
    logic        cmd_gnt_o;
    logic [16:0] cmd_len_i = '0;
    logic [0:0]  cmd_opc_i = '0;
    logic        cmd_inc_i = 1'b0;
    logic [1:0]  cmd_sid_i = '0;
    logic [31:0] tcdm_add_i = '0;
    logic [31:0] ext_add_i = '0;
    logic        tx_req_o;
    logic        tx_gnt_i = 1'b0;
    logic [7:0]  tx_len_o;
    logic [0:0]  tx_opc_o;
    logic [1:0]  tx_sid_o;
    logic [31:0] tx_tcdm_add_o;
    logic [31:0] tx_ext_add_o;
    logic        tx_last_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    mchan_cmd_unpack #(
        .MAX_BURST_BYTES(256),
        .BOUNDARY_LOG2  (12)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cmd_req_i    (cmd_req_i),
        .cmd_gnt_o    (cmd_gnt_o),
        .cmd_len_i    (cmd_len_i),
        .cmd_opc_i    (cmd_opc_i),
        .cmd_inc_i    (cmd_inc_i),
        .cmd_sid_i    (cmd_sid_i),
        .tcdm_add_i   (tcdm_add_i),
        .ext_add_i    (ext_add_i),
        .tx_req_o     (tx_req_o),
        .tx_gnt_i     (tx_gnt_i),
        .tx_len_o     (tx_len_o),
        .tx_opc_o     (tx_opc_o),
        .tx_sid_o     (tx_sid_o),
        .tx_tcdm_add_o(tx_tcdm_add_o),
        .tx_ext_add_o (tx_ext_add_o),
        .tx_last_o    (tx_last_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_cmd(input logic [16:0] len, input logic inc, input logic [0:0] opc,
                            input logic [1:0] sid, input logic [31:0] tcdm, input logic [31:0] ext);
        check("cmd_gnt_ready", 64'(cmd_gnt_o), 64'd1);
        cmd_req_i  = 1'b1;
        cmd_len_i  = len;
        cmd_inc_i  = inc;
        cmd_opc_i  = opc;
        cmd_sid_i  = sid;
        tcdm_add_i = tcdm;
        ext_add_i  = ext;
        step();
        cmd_req_i = 1'b0;
        cmd_len_i = '0;
        tcdm_add_i = '0;
        ext_add_i = '0;
    endtask

    // Checks the burst currently presented, then grants it for one cycle
    task automatic take_burst(input string tag, input logic [7:0] len, input logic [31:0] tcdm,
                              input logic [31:0] ext, input logic last);
        check({tag, ".req"},  64'(tx_req_o), 64'd1);
        check({tag, ".gnt"},  64'(cmd_gnt_o), 64'd0);
        check({tag, ".busy"}, 64'(busy_o), 64'd1);
        check({tag, ".len"},  64'(tx_len_o), 64'(len));
        check({tag, ".tcdm"}, 64'(tx_tcdm_add_o), 64'(tcdm));
        check({tag, ".ext"},  64'(tx_ext_add_o), 64'(ext));
        check({tag, ".last"}, 64'(tx_last_o), 64'(last));
        tx_gnt_i = 1'b1;
        step();
        tx_gnt_i = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".idle_gnt"},  64'(cmd_gnt_o), 64'd1);
        check({tag, ".idle_req"},  64'(tx_req_o), 64'd0);
        check({tag, ".idle_busy"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        logic [7:0]  h_len;
        logic [31:0] h_tcdm, h_ext;
        int nb;

        // Reset state
        #2;
        check("rst_gnt",  64'(cmd_gnt_o), 64'd1);
        check("rst_req",  64'(tx_req_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_last", 64'(tx_last_o), 64'd0);
        check("rst_len",  64'(tx_len_o), 64'd0);
        check("rst_tcdm", 64'(tx_tcdm_add_o), 64'd0);
        check("rst_ext",  64'(tx_ext_add_o), 64'd0);
        step();
        rst_ni = 1'b1;
        step();

        // tx_gnt_i while idle must be ignored
        tx_gnt_i = 1'b1;
        step();
        tx_gnt_i = 1'b0;
        check_idle("gnt_ignored");

        // 1. Single burst, opcode/SID propagation
        send_cmd(17'd15, 1'b1, 1'b1, 2'd3, 32'h100, 32'h1000);
        check("c1.opc", 64'(tx_opc_o), 64'd1);
        check("c1.sid", 64'(tx_sid_o), 64'd3);
        take_burst("c1", 8'd15, 32'h100, 32'h1000, 1'b1);
        check_idle("c1");

        // 2. Multi-burst, back-to-back
        send_cmd(17'd599, 1'b1, 1'b0, 2'd1, 32'h0, 32'h2000);
        take_burst("c2b0", 8'd255, 32'h000, 32'h2000, 1'b0);
        take_burst("c2b1", 8'd255, 32'h100, 32'h2100, 1'b0);
        take_burst("c2b2", 8'd87,  32'h200, 32'h2200, 1'b1);
        check_idle("c2");

        // 3. External boundary crossing
        send_cmd(17'd63, 1'b1, 1'b0, 2'd0, 32'h0, 32'h1FF0);
`ifdef MCHAN_UNPACK_BOUNDARY_EN
        take_burst("c3b0", 8'd15, 32'h00, 32'h1FF0, 1'b0);
        take_burst("c3b1", 8'd47, 32'h10, 32'h2000, 1'b1);
`else
        take_burst("c3b0", 8'd63, 32'h00, 32'h1FF0, 1'b1);
`endif
        check_idle("c3");

        // 4. Backpressure: held outputs for 5 cycles mid-command
        send_cmd(17'd599, 1'b1, 1'b1, 2'd2, 32'h0, 32'h2000);
        take_burst("c4b0", 8'd255, 32'h000, 32'h2000, 1'b0);
        h_len = tx_len_o; h_tcdm = tx_tcdm_add_o; h_ext = tx_ext_add_o;
        for (int i = 0; i < 5; i++) begin
            step();
            check("c4.hold_req",  64'(tx_req_o), 64'd1);
            check("c4.hold_len",  64'(tx_len_o), 64'd255);
            check("c4.hold_tcdm", 64'(tx_tcdm_add_o), 64'h100);
            check("c4.hold_ext",  64'(tx_ext_add_o), 64'h2100);
            check("c4.hold_last", 64'(tx_last_o), 64'd0);
            check("c4.hold_opc",  64'(tx_opc_o), 64'd1);
            check("c4.hold_sid",  64'(tx_sid_o), 64'd2);
            check("c4.hold_gnt",  64'(cmd_gnt_o), 64'd0);
            check("c4.hold_busy", 64'(busy_o), 64'd1);
        end
        check("c4.stable_len", 64'(tx_len_o), 64'(h_len));
        take_burst("c4b1", 8'd255, 32'h100, 32'h2100, 1'b0);
        take_burst("c4b2", 8'd87,  32'h200, 32'h2200, 1'b1);
        check_idle("c4");

        // 5. Fixed external address
        send_cmd(17'd511, 1'b0, 1'b0, 2'd0, 32'h400, 32'h3000);
        take_burst("c5b0", 8'd255, 32'h400, 32'h3000, 1'b0);
        take_burst("c5b1", 8'd255, 32'h500, 32'h3000, 1'b1);
        check_idle("c5");

        // Zero length
        send_cmd(17'd0, 1'b1, 1'b0, 2'd0, 32'h7, 32'h9);
        take_burst("zero", 8'd0, 32'h7, 32'h9, 1'b1);
        check_idle("zero");

        // Maximum length: 2^17 bytes = 512 bursts of 256
        send_cmd(17'h1FFFF, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0);
        nb = 0;
        while (tx_req_o && !tx_last_o && nb < 600) begin
            tx_gnt_i = 1'b1;
            step();
            nb++;
        end
        tx_gnt_i = 1'b0;
        check("max.nonlast_bursts", 64'(nb), 64'd511);
        check("max.last",  64'(tx_last_o), 64'd1);
        check("max.len",   64'(tx_len_o), 64'd255);
        check("max.tcdm",  64'(tx_tcdm_add_o), 64'h1FF00);
        check("max.ext",   64'(tx_ext_add_o), 64'h1FF00);
        tx_gnt_i = 1'b1;
        step();
        tx_gnt_i = 1'b0;
        check_idle("max");

        // 6. Reset asserted during burst 2
        send_cmd(17'd599, 1'b1, 1'b0, 2'd1, 32'h0, 32'h2000);
        take_burst("c6b0", 8'd255, 32'h000, 32'h2000, 1'b0);
        check("c6.pre_req", 64'(tx_req_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("c6.async_req",  64'(tx_req_o), 64'd0);
        check("c6.async_busy", 64'(busy_o), 64'd0);
        check("c6.async_gnt",  64'(cmd_gnt_o), 64'd1);
        step();
        rst_ni = 1'b1;
        step();
        check_idle("c6.post");
        send_cmd(17'd15, 1'b1, 1'b0, 2'd0, 32'h100, 32'h1000);
        take_burst("c6r", 8'd15, 32'h100, 32'h1000, 1'b1);
        check_idle("c6r");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mchan_cmd_unpack.md
# mchan_cmd_unpack

- Consumer end of the MCHAN control-unit command interface.
- Accepts one queued 1D transfer command per handshake: length, opcode, increment flag, SID, TCDM address and external address.
- Splits the command into a sequence of bursts, each bounded by the maximum burst size and, optionally, by the external address boundary.
- Sits between the control interface command FIFOs and the TX/RX transfer queues.

## Interface
Parameters:
- MAX_BURST_BYTES, 256 — largest burst in bytes; power of two, ≤ 2^BOUNDARY_LOG2.
- BOUNDARY_LOG2, 12 — log2 of the external address boundary (4 KiB).
- MCHAN_LEN_WIDTH, 17 — command length width.
- MCHAN_OPC_WIDTH, 1 — opcode width.
- TRANS_SID_WIDTH, 2 — transfer SID width.
- TCDM_ADD_WIDTH, 32 — TCDM address width.
- EXT_ADD_WIDTH, 32 — external address width.
- BURST_LEN_WIDTH, $clog2(MAX_BURST_BYTES) — burst length field width.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_req_i  in  1  command valid.
- cmd_gnt_o  out  1  command accepted.
- cmd_len_i  in  MCHAN_LEN_WIDTH  bytes−1.
- cmd_opc_i  in  MCHAN_OPC_WIDTH  opcode.
- cmd_inc_i  in  1  1 = increment the external address; 0 = fixed external address.
- cmd_sid_i  in  TRANS_SID_WIDTH  transfer ID.
- tcdm_add_i  in  TCDM_ADD_WIDTH  TCDM start address.
- ext_add_i  in  EXT_ADD_WIDTH  external start address.
- tx_req_o  out  1  burst valid.
- tx_gnt_i  in  1  burst accepted.
- tx_len_o  out  BURST_LEN_WIDTH  burst bytes−1.
- tx_opc_o, tx_sid_o  out  as input  latched from the command.
- tx_tcdm_add_o  out  TCDM_ADD_WIDTH  burst TCDM address.
- tx_ext_add_o  out  EXT_ADD_WIDTH  burst external address.
- tx_last_o  out  1  final burst of the command.
- busy_o  out  1  command in progress.

## Operation
State machine:
- IDLE: cmd_gnt_o = 1. On cmd_req_i, latch opc, sid, inc, addresses and rem = cmd_len_i, then go to SPLIT.
- SPLIT: cmd_gnt_o = 0, tx_req_o = 1.
  - On tx_req_o & tx_gnt_i with tx_last_o = 0: advance the command registers and stay in SPLIT.
  - On tx_req_o & tx_gnt_i with tx_last_o = 1: go to IDLE.

Burst size (in bytes), computed from registers only:
- avail = rem + 1, width MCHAN_LEN_WIDTH+1.
- to_bnd = 2^BOUNDARY_LOG2 − ext_add[BOUNDARY_LOG2−1:0], width BOUNDARY_LOG2+1.
- burst = min(avail, MAX_BURST_BYTES, to_bnd); to_bnd applies only with the macro defined and inc = 1.
- tx_len_o = burst − 1.
- tx_last_o = (burst == avail).

Advance on each accepted non-last burst:
- tcdm_add += burst.
- ext_add += burst if inc = 1, otherwise ext_add is unchanged.
- rem −= burst.
- Address sums wrap modulo 2^width.

Other rules:
- busy_o = (state == SPLIT).
- No output has a combinational path from any input.
- Reset values: every output is 0 except cmd_gnt_o = 1; state = IDLE; all registers 0.

## Timing
- Command handshake at cycle N → first burst has tx_req_o = 1 at N+1.
- Bursts are back-to-back: after a granted non-last burst, the next burst is valid the following cycle with no bubble.
- Last burst granted at M → cmd_gnt_o = 1 at M+1, so there is exactly one idle cycle between commands.
- Backpressure: while tx_req_o = 1 and tx_gnt_i = 0, every tx_* output is held stable.
- tx_gnt_i while tx_req_o = 0 is ignored.
- Reset asserted mid-command: tx_req_o drops asynchronously, the command is discarded, and the block is in IDLE on release.
- Zero length: cmd_len_i = 0 gives a single 1-byte burst with tx_last_o = 1.
- Maximum length: cmd_len_i = all-ones is handled without overflow.

## Configuration
- MCHAN_UNPACK_BOUNDARY_EN defined: bursts with inc = 1 never cross a 2^BOUNDARY_LOG2 external boundary.
- Not defined: bursts are limited by MAX_BURST_BYTES and the remaining length only, and the to_bnd logic is not synthesised.

## Test plan
1. Single burst: len=15, ext=0x1000, tcdm=0x100, inc=1 → one burst at N+1 with tx_len_o=15, tx_last_o=1; cmd_gnt_o=1 the cycle after the grant.
2. Multi-burst: len=599, ext=0x2000, tcdm=0x0 → three consecutive bursts:
   - tx_len_o 255 / 255 / 87;
   - ext 0x2000 / 0x2100 / 0x2200;
   - tcdm 0x0 / 0x100 / 0x200;
   - tx_last_o set only on the third.
3. Boundary: ext=0x1FF0, len=63, inc=1.
   - With macro: bursts of len 15 at 0x1FF0, then len 47 at 0x2000.
   - Without macro: one burst of len 63.
4. Backpressure: tx_gnt_i held 0 for 5 cycles mid-command → all tx_* outputs stable, cmd_gnt_o=0, busy_o=1 throughout.
5. Fixed address: inc=0, ext=0x3000, tcdm=0x400, len=511 → two bursts of len 255, both ext 0x3000, tcdm 0x400 / 0x500.
6. Reset mid-command: rst_ni pulsed during burst 2 of case 2 → tx_req_o=0 and busy_o=0 immediately; a subsequent command len=15 completes as in case 1.
